pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use hazards between ID and EX, squashes fetch after taken branches and jumps resolved in ID, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It drives the write-enable, hold and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps a stall-cycle performance counter plus a memory-timeout trap.

## Interface
Parameters:
- MAX_WAIT, 8: maximum consecutive cycles in MEM_WAIT before the timeout trap fires (range 1–255).

Ports:
- clk_i  in  1  pipeline clock; all state updates on the rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- id_rs_addr_i  in  5  RS field of the instruction in ID
- id_rt_addr_i  in  5  RT field of the instruction in ID
- id_uses_rt_i  in  1  the ID instruction reads RT (R-type, beq, sw)
- ex_mem_read_i  in  1  Memory_read control currently held in the ID/EX register
- ex_rt_addr_i  in  5  RT address currently held in the ID/EX register
- branch_taken_i  in  1  branch resolved taken in ID
- jump_i  in  1  jump decoded in ID
- mem_req_i  in  1  MEM stage is issuing a data-memory access
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  load a NOP into IF/ID
- idex_bubble_o  out  1  zero all control bits loaded into ID/EX
- idex_hold_o  out  1  ID/EX keeps its current contents
- exmem_hold_o  out  1  EX/MEM keeps its current contents
- memwb_bubble_o  out  1  zero RegWrite/MemtoReg loaded into MEM/WB
- timeout_o  out  1  sticky memory-timeout trap
- stall_cnt_o  out  16  saturating count of cycles with pc_write_o=0

## Operation
- States: RUN, MEM_WAIT, TRAP. Two bits, registered.
- load_use = ex_mem_read_i & (ex_rt_addr_i != 0) & ((ex_rt_addr_i == id_rs_addr_i) | (id_uses_rt_i & ex_rt_addr_i == id_rt_addr_i)).
- freeze = (RUN & mem_req_i & ~mem_ack_i) | (MEM_WAIT & ~mem_ack_i) | TRAP.
- Priority order: freeze, then load_use, then branch/jump.
- When freeze is active: pc_write_o=0, ifid_write_o=0, idex_hold_o=1, exmem_hold_o=1, memwb_bubble_o=1, ifid_flush_o=0, idex_bubble_o=0.
- When load_use is active and freeze is not: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. Any branch or jump in ID is ignored, because it is re-evaluated the next cycle.
- When branch_taken_i|jump_i is active and neither of the above applies: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
- Otherwise: pc_write_o=1, ifid_write_o=1, and all hold, bubble and flush outputs are 0.
- Transitions:
  - RUN to MEM_WAIT on mem_req_i & ~mem_ack_i.
  - MEM_WAIT to RUN on mem_ack_i. The release takes effect in the same cycle: outputs are unfrozen that cycle.
  - MEM_WAIT to TRAP when wait_cnt reaches MAX_WAIT with no ack.
  - TRAP is held until reset.
- wait_cnt is 8 bits. It clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
- timeout_o=1 in TRAP.
- stall_cnt_o increments on every rising edge where pc_write_o=0 and reset is deasserted. It saturates at 16'hFFFF.

## Timing
- All stall, flush and bubble outputs are combinational (Mealy) from state and the current inputs, so the pipeline registers obey them on the same edge.
- Load-use costs exactly 1 stall cycle. On the next cycle the load has left ID/EX and load_use deasserts.
- Memory wait: with ack arriving N cycles after the request, there are N frozen cycles. With ack in the request cycle, there are 0 frozen cycles and no state change.
- Timeout: TRAP is entered on the edge after MAX_WAIT unacknowledged MEM_WAIT cycles.
- Simultaneous events:
  - mem_req_i with load_use: freeze wins, and load_use is re-evaluated after the release.
  - mem_ack_i arriving in the same cycle the counter hits MAX_WAIT: ack wins and the next state is RUN.
- Reset, asynchronous and taking effect immediately, including mid-wait:
  - State is RUN and wait_cnt=0.
  - timeout_o=0 and stall_cnt_o=0.
  - While rst_n_i=0: pc_write_o=0, ifid_write_o=0, and ifid_flush_o, idex_bubble_o, idex_hold_o, exmem_hold_o, memwb_bubble_o are all 0.

## Test plan
- lw $2 in EX (ex_mem_read_i=1, ex_rt=2), ID add with rs=2 -> exactly one cycle of pc_write_o=0 and idex_bubble_o=1, stall_cnt_o=1. Repeat with ex_rt=0 -> no stall.
- Taken beq in ID -> ifid_flush_o=1 for one cycle. The same beq under load_use -> flush suppressed, stall taken, then flush asserted on the following cycle.
- mem_req_i=1 with mem_ack_i arriving after 3 cycles -> 3 frozen cycles (idex_hold_o=exmem_hold_o=memwb_bubble_o=1), release in the ack cycle, stall_cnt_o=3.
- MAX_WAIT=8, no ack -> TRAP after 8 wait cycles, timeout_o=1, permanent freeze. Then assert rst_n_i=0 -> timeout_o=0, state RUN.
- Reset asserted mid-MEM_WAIT between clock edges -> outputs reach their reset values immediately, not on the next edge. After release, normal RUN behaviour resumes.
- Hold pc_write_o=0 for 65540 cycles -> stall_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The master side is the datapath (hazard sources, control sinks);
// the slave side is the sequencer.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs_addr_i;
  logic [4:0]  id_rt_addr_i;
  logic        id_uses_rt_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rt_addr_i;
  logic        branch_taken_i;
  logic        jump_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        idex_hold_o;
  logic        exmem_hold_o;
  logic        memwb_bubble_o;
  logic        timeout_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_mem_read_i, ex_rt_addr_i,
           branch_taken_i, jump_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, idex_hold_o,
           exmem_hold_o, memwb_bubble_o, timeout_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_addr_i, id_rt_addr_i, id_uses_rt_i, ex_mem_read_i, ex_rt_addr_i,
           branch_taken_i, jump_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, idex_hold_o,
           exmem_hold_o, memwb_bubble_o, timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls,
// fetch squash on taken branch/jump, full freeze during multi-cycle memory
// accesses, a memory-timeout trap and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] TRAP     = 2'd2;

  // Last unacknowledged wait cycle before the trap fires.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  wait_cnt;
  logic [15:0] stall_cnt;
  logic        load_use;
  logic        freeze;

  // Hazard detection: loaded register consumed by the instruction in ID.
  always_comb begin
    load_use = hz.ex_mem_read_i && (hz.ex_rt_addr_i != 5'd0) &&
               ((hz.ex_rt_addr_i == hz.id_rs_addr_i) ||
                (hz.id_uses_rt_i && (hz.ex_rt_addr_i == hz.id_rt_addr_i)));
    freeze   = ((state == RUN) && hz.mem_req_i && !hz.mem_ack_i) ||
               ((state == MEM_WAIT) && !hz.mem_ack_i) ||
               (state == TRAP);
  end

  // Mealy pipeline controls; reset forces every control low immediately.
  always_comb begin
    hz.pc_write_o     = 1'b0;
    hz.ifid_write_o   = 1'b0;
    hz.ifid_flush_o   = 1'b0;
    hz.idex_bubble_o  = 1'b0;
    hz.idex_hold_o    = 1'b0;
    hz.exmem_hold_o   = 1'b0;
    hz.memwb_bubble_o = 1'b0;
    if (rst_n_i) begin
      if (freeze) begin
        hz.idex_hold_o    = 1'b1;
        hz.exmem_hold_o   = 1'b1;
        hz.memwb_bubble_o = 1'b1;
      end else if (load_use) begin
        // Branch/jump in ID is dropped here; it is seen again next cycle.
        hz.idex_bubble_o = 1'b1;
      end else begin
        hz.pc_write_o   = 1'b1;
        hz.ifid_write_o = 1'b1;
        hz.ifid_flush_o = hz.branch_taken_i || hz.jump_i;
      end
    end
  end

  // Next-state logic; an ack always wins over the timeout limit.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (hz.mem_req_i && !hz.mem_ack_i) state_nxt = MEM_WAIT;
      MEM_WAIT: if (hz.mem_ack_i)                  state_nxt = RUN;
                else if (wait_cnt == WAIT_LAST)    state_nxt = TRAP;
      TRAP:     state_nxt = TRAP;
      default:  state_nxt = RUN;
    endcase
  end

  // State, wait counter and saturating stall counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state != MEM_WAIT)
        wait_cnt <= 8'd0;
      else if (!hz.mem_ack_i)
        wait_cnt <= wait_cnt + 8'd1;
      if (!hz.pc_write_o && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign hz.timeout_o   = (state == TRAP);
  assign hz.stall_cnt_o = stall_cnt;

endmodule
